// File: rtl/mem_responder.sv
// mem_responder: instruction/data memory responder for the multicycle RISC-V core.
// Fetch and load are registered with one cycle of latency; a side-band program
// port fills instruction memory (also while rst is high). Sticky error flags
// record out-of-range and misaligned accesses, plus the first faulting address.
// Optional access statistics are built when MEM_STATS_EN is defined; otherwise
// rd_count/wr_count are tied to zero.
module mem_responder #(
    parameter logic [31:0] TEXT_BASE  = 32'h00400000,
    parameter logic [31:0] DATA_BASE  = 32'h10010000,
    parameter int          IMEM_WORDS = 256,
    parameter int          DMEM_WORDS = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] PC,
    output logic [31:0] instr,
    input  logic [31:0] dAddress,
    input  logic [31:0] dWriteData,
    input  logic        MemRead,
    input  logic        MemWrite,
    output logic [31:0] dReadData,
    input  logic        prog_we,
    input  logic [31:0] prog_addr,
    input  logic [31:0] prog_data,
    output logic        err_addr,
    output logic        err_align,
    output logic [31:0] err_first,
    output logic [15:0] rd_count,
    output logic [15:0] wr_count
);

    localparam int          IAW        = $clog2(IMEM_WORDS);
    localparam int          DAW        = $clog2(DMEM_WORDS);
    localparam logic [31:0] IMEM_BYTES = 32'(IMEM_WORDS) << 2;
    localparam logic [31:0] DMEM_BYTES = 32'(DMEM_WORDS) << 2;
    localparam logic [31:0] NOP        = 32'h00000013;

    logic [31:0] imem [IMEM_WORDS];
    logic [31:0] dmem [DMEM_WORDS];

    logic [31:0] f_off, d_off, p_off;
    logic        f_in_range, f_aligned, f_ok;
    logic        d_in_range, d_aligned, d_ok, d_req;
    logic        p_ok;
    logic [IAW-1:0] f_idx, p_idx;
    logic [DAW-1:0] d_idx;

    logic [31:0] instr_q, rdata_q, err_first_q, err_first_d;
    logic        err_addr_q, err_addr_d, err_align_q, err_align_d;

    // Offsets wrap as unsigned, so addresses below the base land out of range.
    assign f_off      = PC - TEXT_BASE;
    assign d_off      = dAddress - DATA_BASE;
    assign p_off      = prog_addr - TEXT_BASE;
    assign f_in_range = f_off < IMEM_BYTES;
    assign f_aligned  = PC[1:0] == 2'b00;
    assign f_ok       = f_in_range && f_aligned;
    assign d_in_range = d_off < DMEM_BYTES;
    assign d_aligned  = dAddress[1:0] == 2'b00;
    assign d_ok       = d_in_range && d_aligned;
    assign d_req      = MemRead || MemWrite;
    assign p_ok       = (p_off < IMEM_BYTES) && (prog_addr[1:0] == 2'b00);
    assign f_idx      = f_off[IAW+1:2];
    assign d_idx      = d_off[DAW+1:2];
    assign p_idx      = p_off[IAW+1:2];

    // Instruction memory write port; deliberately not gated by rst so programs load under reset.
    always_ff @(posedge clk) begin
        if (prog_we && p_ok) imem[p_idx] <= prog_data;
    end

    // Data memory write port; stores in a reset cycle are dropped.
    always_ff @(posedge clk) begin
        if (!rst && MemWrite && d_ok) dmem[d_idx] <= dWriteData;
    end

    // Registered fetch and load; non-blocking reads return the pre-write word.
    always_ff @(posedge clk) begin
        if (rst) begin
            instr_q <= NOP;
            rdata_q <= '0;
        end else begin
            instr_q <= f_ok ? imem[f_idx] : NOP;
            if (MemRead) rdata_q <= d_ok ? dmem[d_idx] : 32'h0;
        end
    end

    // Next-state for sticky fault flags; the data port wins err_first over the PC.
    always_comb begin
        err_addr_d  = err_addr_q  || (d_req && !d_in_range) || !f_in_range;
        err_align_d = err_align_q || (d_req && !d_aligned)  || !f_aligned;
        err_first_d = err_first_q;
        if (!err_addr_q && !err_align_q) begin
            if (d_req && !d_ok)  err_first_d = dAddress;
            else if (!f_ok)      err_first_d = PC;
        end
    end

    // Fault flag registers, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_addr_q  <= 1'b0;
            err_align_q <= 1'b0;
            err_first_q <= '0;
        end else begin
            err_addr_q  <= err_addr_d;
            err_align_q <= err_align_d;
            err_first_q <= err_first_d;
        end
    end

`ifdef MEM_STATS_EN
    logic [15:0] rd_cnt_q, wr_cnt_q;

    // Saturating counts of accepted (non-faulting) loads and stores.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_cnt_q <= '0;
            wr_cnt_q <= '0;
        end else begin
            if (MemRead && d_ok && rd_cnt_q != 16'hFFFF)  rd_cnt_q <= rd_cnt_q + 16'd1;
            if (MemWrite && d_ok && wr_cnt_q != 16'hFFFF) wr_cnt_q <= wr_cnt_q + 16'd1;
        end
    end

    assign rd_count = rd_cnt_q;
    assign wr_count = wr_cnt_q;
`else
    assign rd_count = 16'h0000;
    assign wr_count = 16'h0000;
`endif

    assign instr     = instr_q;
    assign dReadData = rdata_q;
    assign err_addr  = err_addr_q;
    assign err_align = err_align_q;
    assign err_first = err_first_q;

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: a word-level memory model driven by the access rules,
// directed scenarios and a randomized fetch/load/store/program phase.
module tb_mem_responder;

    localparam logic [31:0] TB_TEXT = 32'h00400000;
    localparam logic [31:0] TB_DATA = 32'h10010000;
    localparam logic [31:0] NOP     = 32'h00000013;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] PC, dAddress, dWriteData, prog_addr, prog_data;
    logic        MemRead, MemWrite, prog_we;
    logic [31:0] instr, dReadData, err_first;
    logic        err_addr, err_align;
    logic [15:0] rd_count, wr_count;

    mem_responder dut (
        .clk(clk), .rst(rst), .PC(PC), .instr(instr),
        .dAddress(dAddress), .dWriteData(dWriteData),
        .MemRead(MemRead), .MemWrite(MemWrite), .dReadData(dReadData),
        .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
        .err_addr(err_addr), .err_align(err_align), .err_first(err_first),
        .rd_count(rd_count), .wr_count(wr_count)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference model state.
    logic [31:0] imem_m [256];
    bit          imem_v [256];
    logic [31:0] dmem_m [256];
    bit          dmem_v [256];
    logic [31:0] m_instr, m_rd, m_first;
    bit          m_instr_known, m_rd_known, m_eaddr, m_ealign;
    int          m_rdc, m_wrc;

    function automatic bit in_rng(input logic [31:0] a, input logic [31:0] base);
        logic [31:0] off;
        off = a - base;
        return off < 32'd1024;
    endfunction

    function automatic int widx(input logic [31:0] a, input logic [31:0] base);
        return int'((a - base) / 4);
    endfunction

    // One clock: predict from the pre-edge state, clock the DUT, compare, then commit.
    task automatic step();
        bit f_ok, d_ok, d_req, p_ok;
        f_ok  = in_rng(PC, TB_TEXT) && (PC % 4 == 0);
        d_ok  = in_rng(dAddress, TB_DATA) && (dAddress % 4 == 0);
        d_req = MemRead || MemWrite;
        p_ok  = in_rng(prog_addr, TB_TEXT) && (prog_addr % 4 == 0);
        if (rst) begin
            m_instr = NOP; m_instr_known = 1;
            m_rd = 0; m_rd_known = 1;
            m_eaddr = 0; m_ealign = 0; m_first = 0;
            m_rdc = 0; m_wrc = 0;
        end else begin
            if (f_ok) begin
                m_instr = imem_m[widx(PC, TB_TEXT)];
                m_instr_known = imem_v[widx(PC, TB_TEXT)];
            end else begin
                m_instr = NOP; m_instr_known = 1;
            end
            if (MemRead) begin
                if (d_ok) begin
                    m_rd = dmem_m[widx(dAddress, TB_DATA)];
                    m_rd_known = dmem_v[widx(dAddress, TB_DATA)];
                    if (m_rdc < 65535) m_rdc++;
                end else begin
                    m_rd = 0; m_rd_known = 1;
                end
            end
            if (MemWrite && d_ok) begin
                dmem_m[widx(dAddress, TB_DATA)] = dWriteData;
                dmem_v[widx(dAddress, TB_DATA)] = 1;
                if (m_wrc < 65535) m_wrc++;
            end
            if (!m_eaddr && !m_ealign) begin
                if (d_req && !d_ok)  m_first = dAddress;
                else if (!f_ok)      m_first = PC;
            end
            if (d_req && !in_rng(dAddress, TB_DATA)) m_eaddr = 1;
            if (d_req && dAddress % 4 != 0)         m_ealign = 1;
            if (!in_rng(PC, TB_TEXT))               m_eaddr = 1;
            if (PC % 4 != 0)                        m_ealign = 1;
        end
        if (prog_we && p_ok) begin
            imem_m[widx(prog_addr, TB_TEXT)] = prog_data;
            imem_v[widx(prog_addr, TB_TEXT)] = 1;
        end
        @(posedge clk);
        #1;
        if (m_instr_known) chk("instr", instr, m_instr);
        if (m_rd_known)    chk("dReadData", dReadData, m_rd);
        chk("err_addr", 32'(err_addr), 32'(m_eaddr));
        chk("err_align", 32'(err_align), 32'(m_ealign));
        chk("err_first", err_first, m_first);
`ifdef MEM_STATS_EN
        chk("rd_count", 32'(rd_count), 32'(m_rdc));
        chk("wr_count", 32'(wr_count), 32'(m_wrc));
`else
        chk("rd_count", 32'(rd_count), 32'h0);
        chk("wr_count", 32'(wr_count), 32'h0);
`endif
    endtask

    task automatic idle_data();
        MemRead = 0; MemWrite = 0; prog_we = 0;
    endtask

    task automatic do_load(input logic [31:0] a);
        MemRead = 1; MemWrite = 0; dAddress = a; step(); MemRead = 0;
    endtask

    task automatic do_store(input logic [31:0] a, input logic [31:0] d);
        MemRead = 0; MemWrite = 1; dAddress = a; dWriteData = d; step(); MemWrite = 0;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin imem_v[i] = 0; dmem_v[i] = 0; end
        m_rd = 0; m_rd_known = 0;
        rst = 1; PC = TB_TEXT; dAddress = TB_DATA; dWriteData = 0;
        MemRead = 0; MemWrite = 0; prog_we = 0; prog_addr = TB_TEXT; prog_data = 0;

        // Program load under reset.
        prog_we = 1; prog_addr = TB_TEXT; prog_data = 32'h00500093;
        step();
        chk("reset_instr", instr, NOP);
        chk("reset_rdata", dReadData, 32'h0);
        for (int i = 1; i < 16; i++) begin
            prog_addr = TB_TEXT + 32'(i * 4); prog_data = $urandom; step();
        end
        prog_we = 0;

        // Reset then fetch.
        rst = 0; PC = TB_TEXT; step();
        chk("fetch_word0", instr, 32'h00500093);

        // Store then load.
        do_store(32'h10010008, 32'hDEADBEEF);
        do_load(32'h10010008);
        chk("store_load", dReadData, 32'hDEADBEEF);

        // Simultaneous read/write: read-before-write.
        do_store(32'h10010004, 32'h11111111);
        MemRead = 1; MemWrite = 1; dAddress = 32'h10010004; dWriteData = 32'h22222222;
        step(); idle_data();
        chk("rw_old", dReadData, 32'h11111111);
        do_load(32'h10010004);
        chk("rw_new", dReadData, 32'h22222222);

        // Store during reset is discarded.
        rst = 1; MemWrite = 1; dAddress = 32'h10010004; dWriteData = 32'h33333333;
        step(); rst = 0; idle_data();
        do_load(32'h10010004);
        chk("rst_store_drop", dReadData, 32'h22222222);

        // Prefill data words, then randomized traffic.
        for (int i = 0; i < 16; i++) do_store(TB_DATA + 32'(i * 4), $urandom);
        for (int c = 0; c < 400; c++) begin
            int op;
            PC = TB_TEXT + 32'($urandom_range(0, 15) * 4);
            prog_we = ($urandom_range(0, 3) == 0);
            prog_addr = TB_TEXT + 32'($urandom_range(0, 15) * 4);
            prog_data = $urandom;
            op = $urandom_range(0, 3);
            MemRead  = (op == 1 || op == 3);
            MemWrite = (op == 2 || op == 3);
            dAddress = TB_DATA + 32'($urandom_range(0, 15) * 4);
            dWriteData = $urandom;
            step();
        end
        idle_data(); PC = TB_TEXT;

        // Access counters: 3 good loads, 2 good stores, 1 faulting store.
        rst = 1; step(); rst = 0;
        do_load(32'h10010000); do_load(32'h10010004); do_load(32'h10010008);
        do_store(32'h1001000C, 32'hA5A5A5A5); do_store(32'h10010010, 32'h5A5A5A5A);
        do_store(32'h10010001, 32'h0);
`ifdef MEM_STATS_EN
        chk("rd_count_3", 32'(rd_count), 32'd3);
        chk("wr_count_2", 32'(wr_count), 32'd2);
`endif
        rst = 1; step(); rst = 0;
        chk("rd_count_rst", 32'(rd_count), 32'd0);
        chk("wr_count_rst", 32'(wr_count), 32'd0);

        // Misaligned load, then a later out-of-range fault.
        dmem_m[0] = dmem_m[0];
        do_load(32'h10010002);
        chk("misal_rdata", dReadData, 32'h0);
        chk("misal_align", 32'(err_align), 32'd1);
        chk("misal_addr", 32'(err_addr), 32'd0);
        chk("misal_first", err_first, 32'h10010002);
        do_load(32'h20000000);
        chk("oor_addr", 32'(err_addr), 32'd1);
        chk("oor_first_kept", err_first, 32'h10010002);

        // Fetch out of range.
        rst = 1; step(); rst = 0;
        PC = 32'h00400400; step();
        chk("fetch_oor_instr", instr, NOP);
        chk("fetch_oor_err", 32'(err_addr), 32'd1);
        chk("fetch_oor_first", err_first, 32'h00400400);

        // Same-cycle data and fetch faults: data address wins.
        rst = 1; PC = TB_TEXT; step(); rst = 0;
        PC = 32'h00400406; MemWrite = 1; dAddress = 32'h30000000; step(); idle_data();
        chk("prio_first", err_first, 32'h30000000);
        chk("prio_align", 32'(err_align), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_responder.md
# mem_responder

Memory-side responder for the multicycle RISC-V core. It serves the core's instruction fetch port (PC → instr) and its data port (dAddress/dWriteData/MemRead/MemWrite → dReadData). Both ports use registered, single-cycle-latency accesses, which fits the core's IF/ID/EX/MEM/WB sequencing. A side-band program-load port fills instruction memory, and sticky error flags report bad addresses.

## Interface
Parameters:
- TEXT_BASE, 32'h00400000, byte address of instruction word 0
- DATA_BASE, 32'h10010000, byte address of data word 0
- IMEM_WORDS, 256, instruction memory depth in 32-bit words (power of two)
- DMEM_WORDS, 256, data memory depth in 32-bit words (power of two)

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- PC  in  32  instruction fetch byte address
- instr  out  32  fetched instruction, registered
- dAddress  in  32  data byte address
- dWriteData  in  32  store data
- MemRead  in  1  load request, sampled at rising edge
- MemWrite  in  1  store request, sampled at rising edge
- dReadData  out  32  load data, registered
- prog_we  in  1  instruction memory write strobe
- prog_addr  in  32  instruction memory byte address for prog_we
- prog_data  in  32  instruction word for prog_we
- err_addr  out  1  sticky: an access fell outside its region
- err_align  out  1  sticky: an access address had [1:0] != 0
- err_first  out  32  byte address of the first faulting access
- rd_count  out  16  accepted loads (see Configuration)
- wr_count  out  16  accepted stores (see Configuration)

## Operation
- Offset = addr − base, 32-bit unsigned. In range when offset < WORDS*4. Word index = offset[31:2].
- Fetch, every cycle:
  - In range and aligned: instr ← imem[index(PC)].
  - Otherwise: instr ← 32'h00000013 (NOP), and a fetch fault is raised.
- Load, at an edge with MemRead=1:
  - In range and aligned: dReadData ← dmem[index].
  - Otherwise: dReadData ← 0, and a data fault is raised.
  - MemRead=0: dReadData holds its value.
- Store, at an edge with MemWrite=1:
  - In range and aligned: dmem[index] ← dWriteData, full word.
  - Otherwise: no write, and a data fault is raised.
- MemRead and MemWrite both high at the same address: the load returns the old word and the store still commits (read-before-write).
- prog_we=1: imem[index(prog_addr)] ← prog_data at the edge. Out-of-range or misaligned prog_addr is silently dropped and raises no flag. prog_we is honoured during rst so a program can be loaded under reset.
- prog_we and a fetch to the same word in the same cycle: instr gets the old word.
- Faults:
  - err_addr is set by a range violation; err_align is set by a misalignment. Both may set on one access.
  - err_first latches the faulting address only while both flags are still 0.
  - Priority when several faults occur in one cycle: data-port address first, then PC.
  - Flags clear only on rst.
- Memory arrays are never cleared by rst. Words never written read as X in simulation.

## Timing
- Reset values (edge with rst=1): instr=32'h00000013, dReadData=0, err_addr=0, err_align=0, err_first=0, rd_count=0, wr_count=0.
- Loads and stores are ignored while rst=1.
- Fetch latency is 1 cycle. A PC change at edge N gives the new instr after edge N+1. The core's IF→ID spacing covers this.
- Load latency is 1 cycle. MemRead sampled in the core's MEM state yields dReadData at the MEM→WB edge, stable through WB.
- A store is visible to a load issued in the following cycle.
- There is no handshake or stall: every request completes in one cycle.
- rst asserted mid-access: the access in that cycle is discarded, and any store is not committed.

## Configuration
- MEM_STATS_EN defined:
  - rd_count increments on each accepted load; wr_count increments on each accepted store.
  - Faulting accesses are not counted.
  - Both counters saturate at 16'hFFFF.
- MEM_STATS_EN undefined: rd_count and wr_count are tied to 0 and no counter logic is built. The ports remain so instantiations are unchanged.

## Test plan
- Reset then fetch: under rst, prog_we writes 32'h00500093 at 32'h00400000. Release rst with PC=32'h00400000 → instr=32'h00500093 after the next edge.
- Store then load: store 32'hDEADBEEF to 32'h10010008. In the following cycle, MemRead at the same address → dReadData=32'hDEADBEEF one edge later.
- Simultaneous read/write: 32'h10010004 holds 32'h11111111. MemRead=MemWrite=1 there with dWriteData=32'h22222222 → dReadData=32'h11111111; a subsequent load returns 32'h22222222.
- Misaligned load at 32'h10010002 → dReadData=0, err_align=1, err_addr=0, err_first=32'h10010002. A later fault at 32'h20000000 → err_addr=1, err_first unchanged.
- Fetch out of range at PC=32'h00400400 (IMEM_WORDS=256) → instr=32'h00000013, err_addr=1.
- With MEM_STATS_EN: 3 good loads, 2 good stores and 1 faulting store → rd_count=3, wr_count=2. Assert rst → both counters 0.
